// File: rtl/systolic_pkg.sv
// Shared constants and types for the 4x4 systolic array and its edge logic.
package systolic_pkg;

  // Array edge length; every edge carries this many lanes.
  localparam int ARRAY_N = 4;

  // Default partial-sum width per lane.
  localparam int PS_W = 16;

  // Depth of the tag chain that tracks row starts across the skew.
  localparam int TAG_DEPTH = ARRAY_N - 1;

  // One full row of partial sums, lane 0 in the lowest slot.
  typedef logic [ARRAY_N-1:0][PS_W-1:0] ps_row_t;

endpackage : systolic_pkg

// File: rtl/row_fifo.sv
// Small row FIFO with synchronous reset/clear.
// A push into a full FIFO is still accepted if a pop happens in the same cycle.
// The head entry drives the output directly, so back-to-back pops give one entry per cycle.
module row_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                   Clock,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop_ready,
  output logic                   valid,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push_ok;

  // Handshake decode: a pop frees a slot in the same cycle, letting a push into a full FIFO through.
  always_comb begin
    full      = (count == FULL_COUNT);
    valid     = (count != '0);
    pop       = valid && pop_ready;
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    head_data = valid ? mem[rd_ptr] : '0;
    fill      = count;
  end

  // Entry storage; contents need no reset because the output is masked while empty.
  always_ff @(posedge Clock) begin
    if (push_ok && rst_n && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; reset and clear win over any push or pop in the same cycle.
  always_ff @(posedge Clock) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : row_fifo

// File: rtl/systolic_result_collector.sv
// Receive-side collector for the systolic array bottom edge.
// De-skews the diagonal partial-sum wavefront into whole rows, tags each row
// with its tile position and buffers rows in a small FIFO for the consumer.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DW            = PS_W,
  parameter int DEPTH         = 4,
  parameter int ROWS_PER_TILE = 4
) (
  input  logic                      Clock,
  input  logic                      rst_n,
  input  logic                      data_clear,
  input  logic                      en_shift_bottom,
  input  logic                      ps_valid,
  input  logic [ARRAY_N*DW-1:0]     ps_bottom_out_flat,
  output logic [ARRAY_N*DW-1:0]     row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      row_last,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow
);

  localparam int ROW_W = ARRAY_N * DW;
  localparam int ENT_W = ROW_W + 1;
  localparam int CNT_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(ROWS_PER_TILE - 1);

  logic [DW-1:0] lane0;
  logic [DW-1:0] lane1;
  logic [DW-1:0] lane2;
  logic [DW-1:0] lane3;

  logic [DW-1:0] lane0_d1;
  logic [DW-1:0] lane0_d2;
  logic [DW-1:0] lane0_d3;
  logic [DW-1:0] lane1_d1;
  logic [DW-1:0] lane1_d2;
  logic [DW-1:0] lane2_d1;

  logic [TAG_DEPTH-1:0] tag;
  logic [CNT_W-1:0]     row_cnt;

  logic                 clear_all;
  logic                 row_done;
  logic [ROW_W-1:0]     row_assembled;
  logic [ENT_W-1:0]     push_entry;
  logic [ENT_W-1:0]     head_entry;
  logic                 fifo_drop;

  // Lane split, row completion and entry packing; the oldest tag stage marks a row whose lane 3 is live now.
  always_comb begin
    lane0         = ps_bottom_out_flat[0*DW +: DW];
    lane1         = ps_bottom_out_flat[1*DW +: DW];
    lane2         = ps_bottom_out_flat[2*DW +: DW];
    lane3         = ps_bottom_out_flat[3*DW +: DW];
    clear_all     = !rst_n || data_clear;
    row_done      = en_shift_bottom && tag[TAG_DEPTH-1];
    row_assembled = {lane3, lane2_d1, lane1_d2, lane0_d3};
    push_entry    = {(row_cnt == LAST_POS), row_assembled};
  end

  // Deskew delay lines: lane j is held back (ARRAY_N-1-j) shift events; stalled cycles freeze everything.
  always_ff @(posedge Clock) begin
    if (clear_all) begin
      lane0_d1 <= '0;
      lane0_d2 <= '0;
      lane0_d3 <= '0;
      lane1_d1 <= '0;
      lane1_d2 <= '0;
      lane2_d1 <= '0;
    end else if (en_shift_bottom) begin
      lane0_d1 <= lane0;
      lane0_d2 <= lane0_d1;
      lane0_d3 <= lane0_d2;
      lane1_d1 <= lane1;
      lane1_d2 <= lane1_d1;
      lane2_d1 <= lane2;
    end
  end

  // Row-start tag chain travelling alongside lane 0's delay line.
  always_ff @(posedge Clock) begin
    if (clear_all) begin
      tag <= '0;
    end else if (en_shift_bottom) begin
      tag <= {tag[TAG_DEPTH-2:0], ps_valid};
    end
  end

  // Tile position counter; advances on every completed row, even dropped ones, to keep tile alignment.
  always_ff @(posedge Clock) begin
    if (clear_all) begin
      row_cnt <= '0;
    end else if (row_done) begin
      if (row_cnt == LAST_POS) begin
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow: set when a completed row could not enter the FIFO.
  always_ff @(posedge Clock) begin
    if (clear_all) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  row_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_row_fifo (
    .Clock     (Clock),
    .rst_n     (rst_n),
    .clear     (data_clear),
    .push      (row_done),
    .push_data (push_entry),
    .pop_ready (row_ready),
    .valid     (row_valid),
    .head_data (head_entry),
    .fill      (fill),
    .drop      (fifo_drop)
  );

  // Head entry unpacks straight to the consumer; it reads as zero while the FIFO is empty.
  always_comb begin
    row_data = head_entry[ROW_W-1:0];
    row_last = head_entry[ROW_W];
  end

endmodule : systolic_result_collector

// File: tb/tb_systolic_result_collector.sv
// Directed self-checking bench for systolic_result_collector.
module tb_systolic_result_collector;
  import systolic_pkg::*;

  localparam int DW    = PS_W;
  localparam int DEPTH = 4;
  localparam int RPT   = 4;

  logic              Clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              data_clear = 1'b0;
  logic              en_shift_bottom = 1'b0;
  logic              ps_valid = 1'b0;
  logic [4*DW-1:0]   ps_bottom_out_flat = '0;
  logic [4*DW-1:0]   row_data;
  logic              row_valid;
  logic              row_ready = 1'b0;
  logic              row_last;
  logic [$clog2(DEPTH):0] fill;
  logic              overflow;

  int vectors = 0;
  int miscompares = 0;

  systolic_result_collector #(
    .DW            (DW),
    .DEPTH         (DEPTH),
    .ROWS_PER_TILE (RPT)
  ) dut (
    .Clock              (Clock),
    .rst_n              (rst_n),
    .data_clear         (data_clear),
    .en_shift_bottom    (en_shift_bottom),
    .ps_valid           (ps_valid),
    .ps_bottom_out_flat (ps_bottom_out_flat),
    .row_data           (row_data),
    .row_valid          (row_valid),
    .row_ready          (row_ready),
    .row_last           (row_last),
    .fill               (fill),
    .overflow           (overflow)
  );

  // Free-running 10 ns clock.
  always #5 Clock = ~Clock;

  // Element of test row r on lane j: row number in the high byte, 0x11*(j+1) in the low byte.
  function automatic logic [DW-1:0] elem(input int r, input int j);
    return DW'(r * 256 + (j + 1) * 17);
  endfunction

  // Full expected row r with lane 0 in the low bits.
  function automatic logic [4*DW-1:0] expRow(input int r);
    logic [4*DW-1:0] res;
    for (int j = 0; j < 4; j++) res[j*DW +: DW] = elem(r, j);
    return res;
  endfunction

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, then samples 1 ns after the capturing edge.
  task automatic applyStimulus(input logic en, input logic pv,
                               input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                               input logic [DW-1:0] l2, input logic [DW-1:0] l3);
    en_shift_bottom    = en;
    ps_valid           = pv;
    ps_bottom_out_flat = {l3, l2, l1, l0};
    @(posedge Clock);
    #1;
  endtask

  // Two reset cycles with everything idle.
  task automatic doReset();
    rst_n      = 1'b0;
    data_clear = 1'b0;
    row_ready  = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  // Streams n skewed rows starting at row number 'first'; optional stalls with junk between shifts,
  // optional per-event head checks, and optional single-event ready pulse.
  task automatic shiftRows(input int first, input int n, input bit stall, input bit check_stream,
                           input int ready_event, input int pos_base);
    logic [DW-1:0] ln [4];
    int idx;
    for (int k = 0; k < n + 3; k++) begin
      for (int j = 0; j < 4; j++) ln[j] = (k - j >= 0 && k - j < n) ? elem(first + k - j, j) : '0;
      if (ready_event >= 0) row_ready = (k == ready_event);
      if (stall && k > 0) applyStimulus(1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
      applyStimulus(1'b1, (k < n), ln[0], ln[1], ln[2], ln[3]);
      if (check_stream && k >= 3) begin
        idx = k - 3;
        checkOutput("stream_valid", 64'(row_valid), 64'd1);
        checkOutput("stream_data", row_data, expRow(first + idx));
        checkOutput("stream_last", 64'(row_last), 64'(((pos_base + idx) % RPT) == RPT - 1));
      end
    end
    if (ready_event >= 0) row_ready = 1'b0;
  endtask

  // Pops n rows with ready held high and checks each head, then checks the FIFO is empty.
  task automatic drainRows(input int first, input int n, input int pos_base);
    row_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkOutput("drain_valid", 64'(row_valid), 64'd1);
      checkOutput("drain_data", row_data, expRow(first + i));
      checkOutput("drain_last", 64'(row_last), 64'(((pos_base + i) % RPT) == RPT - 1));
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    end
    checkOutput("drain_empty", 64'(row_valid), 64'd0);
    checkOutput("drain_fill0", 64'(fill), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOutput("empty_pop_fill", 64'(fill), 64'd0);
    row_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_valid", 64'(row_valid), 64'd0);
    checkOutput("rst_fill", 64'(fill), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_data", row_data, 64'd0);
    checkOutput("rst_last", 64'(row_last), 64'd0);

    // Contiguous skewed row, hand-written diagonal
    applyStimulus(1'b1, 1'b1, 16'h0011, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0022, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0033, 16'h0000);
    checkOutput("contig_early", 64'(row_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0044);
    checkOutput("contig_valid", 64'(row_valid), 64'd1);
    checkOutput("contig_data", row_data, 64'h0044_0033_0022_0011);
    checkOutput("contig_fill", 64'(fill), 64'd1);
    checkOutput("contig_last", 64'(row_last), 64'd0);
    drainRows(0, 1, 0);

    // Stalled shifts with junk and ps_valid during stalls
    doReset();
    shiftRows(0, 1, 1'b1, 1'b1, -1, 0);
    checkOutput("stall_data", row_data, 64'h0044_0033_0022_0011);
    checkOutput("stall_fill", 64'(fill), 64'd1);

    // Tile marking over 5 streamed rows with ready high
    doReset();
    row_ready = 1'b1;
    shiftRows(1, 5, 1'b0, 1'b1, -1, 0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOutput("tile_empty", 64'(row_valid), 64'd0);
    row_ready = 1'b0;

    // Overflow: five rows into a four-deep FIFO with no consumer
    doReset();
    shiftRows(1, 5, 1'b0, 1'b0, -1, 0);
    checkOutput("ovf_fill", 64'(fill), 64'd4);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    drainRows(1, 4, 0);
    checkOutput("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a pop in the 5th row's push cycle
    doReset();
    shiftRows(1, 5, 1'b0, 1'b0, 7, 0);
    checkOutput("bypass_fill", 64'(fill), 64'd4);
    checkOutput("bypass_flag", 64'(overflow), 64'd0);
    drainRows(2, 4, 1);

    // Clear mid-row after an overflow, then a clean tile
    doReset();
    shiftRows(1, 5, 1'b0, 1'b0, -1, 0);
    checkOutput("pre_clear_ovf", 64'(overflow), 64'd1);
    applyStimulus(1'b1, 1'b1, elem(9, 0), '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, elem(9, 1), '0, '0);
    data_clear = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    data_clear = 1'b0;
    checkOutput("clear_fill", 64'(fill), 64'd0);
    checkOutput("clear_ovf", 64'(overflow), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, elem(9, 2), '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, elem(9, 3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, '0);
      checkOutput("clear_no_row", 64'(row_valid), 64'd0);
    end
    row_ready = 1'b1;
    shiftRows(11, 4, 1'b0, 1'b1, -1, 0);
    row_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_systolic_result_collector
